// File: rtl/seg7_scan_if.sv
// Display-driver bundle: scan controls and value in, segment/digit drive and frame pulse out.
// Signal names carry the direction as seen by the seg7_scan driver (slave side).
interface seg7_scan_if;
    logic        en_i;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  dig_o;
    logic        frame_o;

    modport master (
        output en_i, value_i, dp_i,
        input  seg_o, dp_o, dig_o, frame_o
    );

    modport slave (
        input  en_i, value_i, dp_i,
        output seg_o, dp_o, dig_o, frame_o
    );
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed 4-digit hex 7-segment scanner with a blanking guard between digits
// and a once-per-frame snapshot of the displayed value and decimal points.
module seg7_scan #(
    parameter int CLK_HZ         = 27_000_000,
    parameter int DIGIT_HZ       = 1_000,
    parameter int BLANK_CYC      = 27,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_DIG = 1'b1,
    parameter bit LZ_SUPPRESS    = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    seg7_scan_if.slave  bus
);
    localparam int DWELL = CLK_HZ / DIGIT_HZ;
    localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    generate
        if (!(DWELL > BLANK_CYC && BLANK_CYC >= 1)) begin : g_bad_cfg
            $error("seg7_scan: configuration requires DWELL > BLANK_CYC >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    digit_q;
    logic [15:0]   snap_val_q;
    logic [3:0]    snap_dp_q;
    logic          snap_pend_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic [3:0]    dig_q;
    logic          frame_q;

    logic [6:0]    seg_pat [4];
    logic [3:0]    zero_hi;
    logic          dark_d;
    logic [6:0]    seg_d;
    logic [3:0]    dig_d;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    // zero_hi[n]: nibble n and every nibble above it are zero in the snapshot.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign seg_pat[gi] = hex7(snap_val_q[4*gi +: 4]);
            assign zero_hi[gi] = (snap_val_q[15:4*gi] == '0);
        end
    endgenerate

    always_comb begin
        dark_d = LZ_SUPPRESS && (digit_q != 2'd0) && zero_hi[digit_q];
        seg_d  = dark_d ? 7'h00 : seg_pat[digit_q];
        dig_d  = dark_d ? 4'b0000 : (4'b0001 << digit_q);
    end

    // Reset lands in BLANK with a pending snapshot so the first frame starts on the next edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            digit_q     <= 2'd0;
            snap_val_q  <= '0;
            snap_dp_q   <= '0;
            snap_pend_q <= 1'b1;
            seg_q       <= '0;
            dp_q        <= 1'b0;
            dig_q       <= '0;
            frame_q     <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (!bus.en_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                digit_q <= 2'd0;
                seg_q   <= '0;
                dp_q    <= 1'b0;
                dig_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q     <= ST_BLANK;
                        cnt_q       <= '0;
                        digit_q     <= 2'd0;
                        snap_val_q  <= bus.value_i;
                        snap_dp_q   <= bus.dp_i;
                        snap_pend_q <= 1'b0;
                        frame_q     <= 1'b1;
                    end
                    ST_BLANK: begin
                        if (snap_pend_q) begin
                            snap_val_q  <= bus.value_i;
                            snap_dp_q   <= bus.dp_i;
                            snap_pend_q <= 1'b0;
                            frame_q     <= 1'b1;
                        end else if (cnt_q == BLANK_LAST) begin
                            state_q <= ST_DRIVE;
                            cnt_q   <= cnt_q + CW'(1);
                            seg_q   <= seg_d;
                            dp_q    <= snap_dp_q[digit_q];
                            dig_q   <= dig_d;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_DRIVE: begin
                        if (cnt_q == DWELL_LAST) begin
                            state_q <= ST_BLANK;
                            cnt_q   <= '0;
                            digit_q <= digit_q + 2'd1;
                            seg_q   <= '0;
                            dp_q    <= 1'b0;
                            dig_q   <= '0;
                            // Wrapping past digit 3 starts a new frame.
                            if (digit_q == 2'd3) begin
                                snap_val_q <= bus.value_i;
                                snap_dp_q  <= bus.dp_i;
                                frame_q    <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        digit_q <= 2'd0;
                        seg_q   <= '0;
                        dp_q    <= 1'b0;
                        dig_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.seg_o   = ACTIVE_LOW_SEG ? ~seg_q : seg_q;
    assign bus.dp_o    = ACTIVE_LOW_SEG ? ~dp_q  : dp_q;
    assign bus.dig_o   = ACTIVE_LOW_DIG ? ~dig_q : dig_q;
    assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: DWELL=10, BLANK_CYC=2, active-high outputs,
// one instance without and one with leading-zero suppression (value fixed at 16'h0030).
module tb_seg7_scan;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    seg7_scan_if bus_m ();
    seg7_scan_if bus_lz ();

    seg7_scan #(
        .CLK_HZ(1000), .DIGIT_HZ(100), .BLANK_CYC(2),
        .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_DIG(1'b0), .LZ_SUPPRESS(1'b0)
    ) u_dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus_m.slave)
    );

    seg7_scan #(
        .CLK_HZ(1000), .DIGIT_HZ(100), .BLANK_CYC(2),
        .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_DIG(1'b0), .LZ_SUPPRESS(1'b1)
    ) u_dut_lz (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus_lz.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_off(input string tag);
        chk({tag, "_dig"},    16'(bus_m.dig_o),    16'h0);
        chk({tag, "_seg"},    16'(bus_m.seg_o),    16'h0);
        chk({tag, "_dp"},     16'(bus_m.dp_o),     16'h0);
        chk({tag, "_frame"},  16'(bus_m.frame_o),  16'h0);
        chk({tag, "_lz_dig"}, 16'(bus_lz.dig_o),   16'h0);
        chk({tag, "_lz_seg"}, 16'(bus_lz.seg_o),   16'h0);
    endtask

    // One digit slot: 2 dark cycles (frame pulse on the first if expected), then 8 lit cycles.
    // Optionally changes value_i at cycle chg_at of the slot.
    task automatic slot(input int d, input logic [6:0] seg_e, input logic dp_e,
                        input logic frame_e, input int chg_at, input logic [15:0] chg_val);
        logic [3:0] dig_e;
        logic [3:0] lz_dig_e;
        logic [6:0] lz_seg_e;
        dig_e    = 4'(4'b0001 << d);
        lz_dig_e = (d <= 1) ? dig_e : 4'b0000;
        lz_seg_e = (d == 0) ? 7'h3F : ((d == 1) ? 7'h4F : 7'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == chg_at) bus_m.value_i = chg_val;
            if (i < 2) begin
                chk("blank_dig",   16'(bus_m.dig_o),   16'h0);
                chk("blank_seg",   16'(bus_m.seg_o),   16'h0);
                chk("blank_frame", 16'(bus_m.frame_o), (i == 0) ? 16'(frame_e) : 16'h0);
                chk("lz_blank_dig",   16'(bus_lz.dig_o),   16'h0);
                chk("lz_blank_frame", 16'(bus_lz.frame_o), (i == 0) ? 16'(frame_e) : 16'h0);
            end else begin
                chk("drive_dig",   16'(bus_m.dig_o),   16'(dig_e));
                chk("drive_seg",   16'(bus_m.seg_o),   16'(seg_e));
                chk("drive_dp",    16'(bus_m.dp_o),    16'(dp_e));
                chk("drive_frame", 16'(bus_m.frame_o), 16'h0);
                chk("lz_drive_dig", 16'(bus_lz.dig_o), 16'(lz_dig_e));
                chk("lz_drive_seg", 16'(bus_lz.seg_o), 16'(lz_seg_e));
                chk("lz_drive_dp",  16'(bus_lz.dp_o),  16'h0);
            end
        end
        $display("slot digit=%0d seg=%h dp=%b frame=%b lz_dig=%b lz_seg=%h checks=%0d failures=%0d",
                 d, seg_e, dp_e, frame_e, lz_dig_e, lz_seg_e, checks, failures);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b0;
        bus_m.en_i      = 1'b0;
        bus_m.value_i   = 16'h0000;
        bus_m.dp_i      = 4'b0000;
        bus_lz.en_i     = 1'b0;
        bus_lz.value_i  = 16'h0030;
        bus_lz.dp_i     = 4'b0000;

        // Asynchronous reset asserted between clock edges.
        tick();
        rst = 1'b1;
        #1;
        chk_all_off("async_reset");
        $display("reset asserted between edges, outputs checked");

        // Scan 16'h12AF with DP on digit 2.
        bus_m.en_i    = 1'b1;
        bus_lz.en_i   = 1'b1;
        bus_m.value_i = 16'h12AF;
        bus_m.dp_i    = 4'b0100;
        tick();
        rst = 1'b0;
        slot(0, 7'h71, 1'b0, 1'b1, -1, 16'h0);
        slot(1, 7'h77, 1'b0, 1'b0, -1, 16'h0);
        slot(2, 7'h5B, 1'b1, 1'b0, -1, 16'h0);
        slot(3, 7'h06, 1'b0, 1'b0, -1, 16'h0);

        // Value goes to zero while digit 1 is lit; stays hidden until the next frame.
        slot(0, 7'h71, 1'b0, 1'b1, -1, 16'h0);
        slot(1, 7'h77, 1'b0, 1'b0, 5, 16'h0000);
        slot(2, 7'h5B, 1'b1, 1'b0, -1, 16'h0);
        slot(3, 7'h06, 1'b0, 1'b0, -1, 16'h0);
        slot(0, 7'h3F, 1'b0, 1'b1, -1, 16'h0);
        slot(1, 7'h3F, 1'b0, 1'b0, -1, 16'h0);
        slot(2, 7'h3F, 1'b1, 1'b0, -1, 16'h0);
        slot(3, 7'h3F, 1'b0, 1'b0, -1, 16'h0);

        // Drop enable in the middle of digit 0 drive.
        tick();
        chk("frame_before_drop", 16'(bus_m.frame_o), 16'h1);
        for (int i = 0; i < 4; i++) tick();
        chk("lit_before_drop", 16'(bus_m.dig_o), 16'h1);
        bus_m.en_i  = 1'b0;
        bus_lz.en_i = 1'b0;
        tick();
        chk_all_off("en_drop");
        tick();
        chk_all_off("en_low_hold");
        $display("enable dropped mid-drive, outputs checked");

        // Re-enable with a new value: immediate frame, 2 dark cycles, digit 0 lights.
        bus_m.value_i = 16'hBEC5;
        bus_m.en_i    = 1'b1;
        bus_lz.en_i   = 1'b1;
        slot(0, 7'h6D, 1'b0, 1'b1, -1, 16'h0);
        slot(1, 7'h39, 1'b0, 1'b0, -1, 16'h0);
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_dig", 16'(bus_m.dig_o), 16'h4);
        chk("pre_rst_seg", 16'(bus_m.seg_o), 16'h79);
        chk("pre_rst_dp",  16'(bus_m.dp_o),  16'h1);

        // Reset during digit 2 drive; scan restarts at digit 0 with a fresh snapshot.
        rst = 1'b1;
        #1;
        chk_all_off("mid_drive_reset");
        $display("reset pulsed during digit 2 drive, outputs checked");
        bus_m.value_i = 16'h3210;
        bus_m.dp_i    = 4'b0001;
        tick();
        rst = 1'b0;
        slot(0, 7'h3F, 1'b1, 1'b1, -1, 16'h0);
        slot(1, 7'h06, 1'b0, 1'b0, -1, 16'h0);
        slot(2, 7'h5B, 1'b0, 1'b0, -1, 16'h0);
        slot(3, 7'h4F, 1'b0, 1'b0, -1, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
